// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings (PLL wrapper, reset tree).
// LOCK_LOSS_CNT_EN adds the lock-loss counter output.
interface pll_lock_sequencer_if;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [2:0] state_o;
`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  modport master (
    output pll_locked, force_relock,
`ifdef LOCK_LOSS_CNT_EN
    input  lock_loss_cnt,
`endif
    input  pll_rst, sys_rst, ready, fault, state_o
  );

  modport slave (
    input  pll_locked, force_relock,
`ifdef LOCK_LOSS_CNT_EN
    output lock_loss_cnt,
`endif
    output pll_rst, sys_rst, ready, fault, state_o
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on the free-running reference clock: hold, wait for lock, qualify, release.
// Optional feature macro: LOCK_LOSS_CNT_EN (saturating count of lock losses while running).
module pll_lock_sequencer #(
  parameter int RST_HOLD_CYCLES     = 100,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                 i_refclk,
  input  logic                 i_rst,
  pll_lock_sequencer_if.slave  bus
);

  localparam int HOLD_W  = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int STAB_W  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int TMO_W   = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic [STAB_W-1:0]      r_stab_cnt;
  logic [TMO_W-1:0]       r_tmo_cnt;
  logic [RETRY_W-1:0]     r_retry_cnt;
  logic                   r_pll_rst;
  logic                   r_sys_rst;
  logic                   r_ready;
  logic                   r_fault;

  state_t                 w_state_next;
  logic                   w_locked_s;
  logic                   w_timeout;
  logic                   w_locking;
  logic [RETRY_W-1:0]     w_retry_inc;

  assign w_locked_s  = r_sync[SYNC_STAGES-1];
  assign w_locking   = (r_state == S_WAIT) || (r_state == S_STABLE);
  assign w_timeout   = w_locking && (r_tmo_cnt == TMO_LAST);
  assign w_retry_inc = r_retry_cnt + 1'b1;

  // Timeout wins over both lock detection and stable-complete.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HOLD:   if (r_hold_cnt == HOLD_LAST) w_state_next = S_WAIT;
      S_WAIT: begin
        if (w_timeout)       w_state_next = (w_retry_inc == RETRY_MAX) ? S_FAULT : S_HOLD;
        else if (w_locked_s) w_state_next = S_STABLE;
      end
      S_STABLE: begin
        if (w_timeout)                    w_state_next = (w_retry_inc == RETRY_MAX) ? S_FAULT : S_HOLD;
        else if (!w_locked_s)             w_state_next = S_WAIT;
        else if (r_stab_cnt == STAB_LAST) w_state_next = S_RUN;
      end
      S_RUN:    if (!w_locked_s || bus.force_relock) w_state_next = S_HOLD;
      S_FAULT:  if (bus.force_relock) w_state_next = S_HOLD;
      default:  w_state_next = S_HOLD;
    endcase
  end

  always_ff @(posedge i_refclk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_HOLD;
      r_sync      <= '0;
      r_hold_cnt  <= '0;
      r_stab_cnt  <= '0;
      r_tmo_cnt   <= '0;
      r_retry_cnt <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pll_rst <= (w_state_next == S_HOLD) || (w_state_next == S_FAULT);
      r_sys_rst <= (w_state_next != S_RUN);
      r_ready   <= (w_state_next == S_RUN);
      r_fault   <= (w_state_next == S_FAULT);

      // Lock flag is meaningless while the PLL is held in reset, so keep the chain flushed.
      if (r_pll_rst) r_sync <= '0;
      else           r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pll_locked};

      if (r_state == S_HOLD && w_state_next == S_HOLD) begin
        if (r_hold_cnt != HOLD_LAST) r_hold_cnt <= r_hold_cnt + 1'b1;
      end else begin
        r_hold_cnt <= '0;
      end

      if (r_state == S_STABLE && w_state_next == S_STABLE) begin
        if (r_stab_cnt != STAB_LAST) r_stab_cnt <= r_stab_cnt + 1'b1;
      end else begin
        r_stab_cnt <= '0;
      end

      // One timeout budget spans WAIT and STABLE, including bounces between them.
      if (w_locking && (w_state_next == S_WAIT || w_state_next == S_STABLE)) begin
        if (r_tmo_cnt != TMO_LAST) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
        r_tmo_cnt <= '0;
      end

      if (w_timeout)                                    r_retry_cnt <= w_retry_inc;
      else if (w_state_next == S_RUN)                   r_retry_cnt <= '0;
      else if (r_state == S_FAULT && w_state_next == S_HOLD) r_retry_cnt <= '0;
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] r_lock_loss_cnt;

  always_ff @(posedge i_refclk or posedge i_rst) begin
    if (i_rst) begin
      r_lock_loss_cnt <= 8'd0;
    end else if (r_state == S_RUN && !w_locked_s && r_lock_loss_cnt != 8'hFF) begin
      r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
    end
  end

  assign bus.lock_loss_cnt = r_lock_loss_cnt;
`endif

  assign bus.pll_rst = r_pll_rst;
  assign bus.sys_rst = r_sys_rst;
  assign bus.ready   = r_ready;
  assign bus.fault   = r_fault;
  assign bus.state_o = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small sim parameters (hold 4, stable 8, timeout 32, retries 2, sync 2).
// Inputs change and outputs are sampled on the falling edge; "edge N" counts rising edges after rst release.
module tb_pll_lock_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pll_lock_sequencer_if bus_if ();

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES    (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2),
    .SYNC_STAGES        (2)
  ) dut (
    .i_refclk(clk),
    .i_rst   (rst),
    .bus     (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_llc(input string tag, input logic [7:0] exp);
`ifdef LOCK_LOSS_CNT_EN
    check(tag, bus_if.lock_loss_cnt, exp);
`else
    if (exp === 8'hxx) $display("%s skipped", tag);
`endif
  endtask

  initial begin
    bus_if.pll_locked   = 1'b0;
    bus_if.force_relock = 1'b0;
    tick(3);
    check("rst_pll_rst", 8'(bus_if.pll_rst), 8'd1);
    check("rst_sys_rst", 8'(bus_if.sys_rst), 8'd1);
    check("rst_ready",   8'(bus_if.ready),   8'd0);
    check("rst_fault",   8'(bus_if.fault),   8'd0);
    check("rst_state",   8'(bus_if.state_o), 8'd0);
    check_llc("rst_llc", 8'd0);

    // Clean lock: pll_rst high 4 cycles, ready 11 edges after WAIT_LOCK entry (edge 4).
    bus_if.pll_locked = 1'b1;
    rst = 1'b0;
    tick(3);
    check("t1_hold_e3_pll_rst", 8'(bus_if.pll_rst), 8'd1);
    check("t1_hold_e3_state",   8'(bus_if.state_o), 8'd0);
    tick(1);
    check("t1_wait_e4_pll_rst", 8'(bus_if.pll_rst), 8'd0);
    check("t1_wait_e4_state",   8'(bus_if.state_o), 8'd1);
    tick(10);
    check("t1_e14_ready",   8'(bus_if.ready),   8'd0);
    check("t1_e14_state",   8'(bus_if.state_o), 8'd2);
    tick(1);
    check("t1_e15_ready",   8'(bus_if.ready),   8'd1);
    check("t1_e15_sys_rst", 8'(bus_if.sys_rst), 8'd0);
    check("t1_e15_state",   8'(bus_if.state_o), 8'd3);

    // Lock loss in RUN: low first sampled at edge 18, sys_rst rises on edge 20.
    tick(2);
    bus_if.pll_locked = 1'b0;
    tick(2);
    check("t4_e19_ready",   8'(bus_if.ready),   8'd1);
    tick(1);
    check("t4_e20_sys_rst", 8'(bus_if.sys_rst), 8'd1);
    check("t4_e20_ready",   8'(bus_if.ready),   8'd0);
    check("t4_e20_state",   8'(bus_if.state_o), 8'd0);
    check("t4_e20_pll_rst", 8'(bus_if.pll_rst), 8'd1);
    check_llc("t4_llc", 8'd1);

    // No lock: two HOLD(4)+WAIT(32) attempts, then sticky FAULT.
    tick(4);
    check("t2_wait1_state", 8'(bus_if.state_o), 8'd1);
    tick(31);
    check("t2_wait1_end",   8'(bus_if.state_o), 8'd1);
    tick(1);
    check("t2_retry_hold",  8'(bus_if.state_o), 8'd0);
    check("t2_retry_prst",  8'(bus_if.pll_rst), 8'd1);
    tick(4);
    check("t2_wait2_state", 8'(bus_if.state_o), 8'd1);
    tick(32);
    check("t2_fault_state", 8'(bus_if.state_o), 8'd4);
    check("t2_fault_flag",  8'(bus_if.fault),   8'd1);
    check("t2_fault_prst",  8'(bus_if.pll_rst), 8'd1);
    check("t2_fault_srst",  8'(bus_if.sys_rst), 8'd1);
    tick(20);
    check("t2_sticky_flag", 8'(bus_if.fault),   8'd1);
    check("t2_sticky_state",8'(bus_if.state_o), 8'd4);

    // Relock from FAULT: retry count cleared, so one timeout returns to HOLD, not FAULT.
    bus_if.force_relock = 1'b1;
    tick(1);
    bus_if.force_relock = 1'b0;
    check("t5_relock_state", 8'(bus_if.state_o), 8'd0);
    check("t5_relock_fault", 8'(bus_if.fault),   8'd0);
    tick(4);
    check("t5_wait_state",   8'(bus_if.state_o), 8'd1);
    tick(32);
    check("t5_retry_clear",  8'(bus_if.state_o), 8'd0);
    bus_if.pll_locked = 1'b1;
    tick(4);
    check("t5_wait2_state",  8'(bus_if.state_o), 8'd1);
    tick(10);
    check("t5_pre_run_rdy",  8'(bus_if.ready),   8'd0);
    tick(1);
    check("t5_run_ready",    8'(bus_if.ready),   8'd1);
    check("t5_run_state",    8'(bus_if.state_o), 8'd3);
    bus_if.force_relock = 1'b1;
    tick(1);
    bus_if.force_relock = 1'b0;
    check("t5_force_state",  8'(bus_if.state_o), 8'd0);
    check("t5_force_srst",   8'(bus_if.sys_rst), 8'd1);
    check("t5_force_ready",  8'(bus_if.ready),   8'd0);
    check_llc("t5_llc_same", 8'd1);

    // Async reset mid-STABLE (stab_cnt=5): outputs return without a clock edge.
    tick(4);
    tick(3);
    check("t6_stable_state", 8'(bus_if.state_o), 8'd2);
    tick(5);
    check("t6_pre_prst",     8'(bus_if.pll_rst), 8'd0);
    rst = 1'b1;
    #1;
    check("t6_async_prst",   8'(bus_if.pll_rst), 8'd1);
    check("t6_async_srst",   8'(bus_if.sys_rst), 8'd1);
    check("t6_async_ready",  8'(bus_if.ready),   8'd0);
    check("t6_async_fault",  8'(bus_if.fault),   8'd0);
    check("t6_async_state",  8'(bus_if.state_o), 8'd0);
    check_llc("t6_async_llc", 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full sequence again; one-cycle dropout while STABLE (low sampled on edge 10).
    tick(4);
    check("t3_wait_state",   8'(bus_if.state_o), 8'd1);
    tick(3);
    check("t3_stable_state", 8'(bus_if.state_o), 8'd2);
    tick(2);
    bus_if.pll_locked = 1'b0;
    tick(1);
    bus_if.pll_locked = 1'b1;
    tick(2);
    check("t3_back_wait",    8'(bus_if.state_o), 8'd1);
    check("t3_back_ready",   8'(bus_if.ready),   8'd0);
    tick(1);
    check("t3_restable",     8'(bus_if.state_o), 8'd2);
    tick(7);
    check("t3_e20_ready",    8'(bus_if.ready),   8'd0);
    tick(1);
    check("t3_e21_ready",    8'(bus_if.ready),   8'd1);
    check("t3_e21_srst",     8'(bus_if.sys_rst), 8'd0);
    check("t3_e21_state",    8'(bus_if.state_o), 8'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
